// File: rtl/data_mem_ctrl.sv
// Load/store access unit: turns one EX-stage load/store into a data-SRAM request/response and stalls until it completes.
// Optional MISALIGN_EXC_EN: misaligned half/word accesses raise adel/ades instead of being issued.
module data_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_req,
  input  logic        ex_we,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stallreq,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        adel,
  output logic        ades,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is presented while data_sram_req=1 and is accepted in the
  // cycle data_sram_addr_ok=1; the response is the later cycle with data_sram_data_ok=1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_data_q;
  logic        ld_valid_q;

  logic        misaligned;
  logic        in_idle;
  logic [3:0]  wstrb_fmt;
  logic [31:0] wdata_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data_d;

  assign in_idle = (state_q == S_IDLE);

`ifdef MISALIGN_EXC_EN
  assign misaligned = ((ex_size == 2'b01) & ex_addr[0]) | (ex_size[1] & (|ex_addr[1:0]));
  assign adel       = in_idle & ex_req & misaligned & ~ex_we;
  assign ades       = in_idle & ex_req & misaligned & ex_we;
`else
  assign misaligned = 1'b0;
  assign adel       = 1'b0;
  assign ades       = 1'b0;
`endif

  // Combinational in IDLE so the issuing instruction is held in EX on its first cycle.
  assign stallreq = (in_idle & ex_req & ~misaligned) |
                    (state_q == S_REQ) | (state_q == S_WAIT);

  always_comb begin
    wstrb_fmt = 4'b0000;
    wdata_fmt = 32'h0;
    if (ex_we) begin
      case (ex_size)
        2'b00: begin
          wstrb_fmt = 4'b0001 << ex_addr[1:0];
          wdata_fmt = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_fmt = ex_addr[1] ? 4'b1100 : 4'b0011;
          wdata_fmt = {2{ex_wdata[15:0]}};
        end
        default: begin
          wstrb_fmt = 4'b1111;
          wdata_fmt = ex_wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel  = data_sram_rdata[{lane_q, 3'b000} +: 8];
    half_sel  = lane_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    ld_data_d = data_sram_rdata;
    case (size_q)
      2'b00:   ld_data_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   ld_data_d = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: ld_data_d = data_sram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'h0;
      ld_data_q  <= 32'h0;
      ld_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ld_valid_q <= 1'b0;
          if (ex_req && !misaligned) begin
            wr_q    <= ex_we;
            size_q  <= ex_size;
            uns_q   <= ex_unsigned;
            lane_q  <= ex_addr[1:0];
            addr_q  <= {ex_addr[31:2], 2'b00};
            wstrb_q <= wstrb_fmt;
            wdata_q <= wdata_fmt;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_sram_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_sram_data_ok) begin
            if (!wr_q) begin
              ld_data_q  <= ld_data_d;
              ld_valid_q <= 1'b1;
            end
            state_q <= S_DONE;
          end
        end
        default: begin
          ld_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign data_sram_req   = req_q;
  assign data_sram_wr    = wr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
  assign ld_data         = ld_data_q;
  assign ld_valid        = ld_valid_q;
  assign dbg_state_o     = state_q;

endmodule
